// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;

    localparam logic [31:0] RV32I_NOP   = 32'h0000_0013;
    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

    // One fetch-buffer entry: the instruction word and the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_entry_t;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus: redirect/stall from the pipeline, IMem req/gnt/rvalid, IF_* to decode.
interface if_fetch_unit_if;

    logic        ID_Stall;
    logic        Redirect_valid;
    logic [31:0] Redirect_PC;
    logic        IMem_req;
    logic [31:0] IMem_addr;
    logic        IMem_gnt;
    logic        IMem_rvalid;
    logic [31:0] IMem_rdata;
    logic        IF_valid;
    logic [31:0] IF_PC;
    logic [31:0] IF_Instruction;
    logic        IF_Misaligned;

    // Fetch unit side.
    modport master (
        input  ID_Stall, Redirect_valid, Redirect_PC,
        input  IMem_gnt, IMem_rvalid, IMem_rdata,
        output IMem_req, IMem_addr,
        output IF_valid, IF_PC, IF_Instruction, IF_Misaligned
    );

    // Memory / pipeline side.
    modport slave (
        output ID_Stall, Redirect_valid, Redirect_PC,
        output IMem_gnt, IMem_rvalid, IMem_rdata,
        input  IMem_req, IMem_addr,
        input  IF_valid, IF_PC, IF_Instruction, IF_Misaligned
    );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small synchronous FIFO with flush; head is visible combinationally.
module if_fetch_unit_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // Flush wins over both push and pop; a full FIFO may still accept when popping.
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues IMem reads, buffers returned words for decode,
// and squashes wrong-path fetches (including in-flight ones) on EX redirects.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = IF_RESET_PC,
    parameter int          FIFO_DEPTH      = 2,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    if_fetch_unit_if.master bus
);

    localparam int FCW = $clog2(FIFO_DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [OCW-1:0] outstanding_q, outstanding_d;
    logic [OCW-1:0] discard_q, discard_d;
    logic           misaligned_q, misaligned_d;

    logic           issue, hs, rsp;
    logic           fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
    logic [FCW-1:0] fifo_count;
    if_entry_t      fifo_head, fifo_in;
    logic [31:0]    tag_head;
    logic [OCW-1:0] tag_count;
    logic           tag_empty, tag_full;

    // Request only when both the in-flight limit and the buffer space reserved for
    // every in-flight word allow it; a redirect cycle never issues.
    always_comb begin
        issue = !Reset && !bus.Redirect_valid
             && (int'(outstanding_q) < MAX_OUTSTANDING)
             && (int'(fifo_count) + int'(outstanding_q) < FIFO_DEPTH);
    end

    assign hs       = issue && bus.IMem_gnt;
    assign rsp      = bus.IMem_rvalid && (outstanding_q != '0);
    assign fifo_in  = '{pc: tag_head, instr: bus.IMem_rdata};
    assign fifo_pop = !fifo_empty && !bus.ID_Stall;

    // Next-state: redirect has priority, then grant/response bookkeeping.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + OCW'(hs) - OCW'(rsp);
        discard_d     = discard_q;
        misaligned_d  = 1'b0;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        if (bus.Redirect_valid) begin
            // Everything still in flight after this cycle is wrong-path; a same-cycle
            // response is dropped outright and already excluded from outstanding_d.
            fetch_pc_d   = word_align(bus.Redirect_PC);
            fifo_flush   = 1'b1;
            discard_d    = outstanding_d;
            misaligned_d = |bus.Redirect_PC[1:0];
        end else begin
            if (hs) fetch_pc_d = fetch_pc_q + 32'd4;
            if (rsp) begin
                if (discard_q != '0) discard_d = discard_q - OCW'(1);
                else                 fifo_push = 1'b1;
            end
        end
    end

    // Fetch state registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            misaligned_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            misaligned_q  <= misaligned_d;
        end
    end

    // Instruction buffer feeding decode.
    if_fetch_unit_fifo #(.WIDTH($bits(if_entry_t)), .DEPTH(FIFO_DEPTH)) u_ibuf (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .push_i      (fifo_push),
        .push_data_i (fifo_in),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

    // PC of each granted request, matched to responses in order. Not flushed on
    // redirect: discarded responses still pop their tag.
    if_fetch_unit_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_tagq (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .push_i      (hs),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp),
        .flush_i     (1'b0),
        .head_o      (tag_head),
        .count_o     (tag_count),
        .empty_o     (tag_empty),
        .full_o      (tag_full)
    );

    assign bus.IMem_req       = issue;
    assign bus.IMem_addr      = fetch_pc_q;
    assign bus.IF_valid       = !fifo_empty;
    assign bus.IF_PC          = fifo_empty ? 32'h0 : fifo_head.pc;
    assign bus.IF_Instruction = fifo_empty ? RV32I_NOP : fifo_head.instr;
    assign bus.IF_Misaligned  = misaligned_q;

    a_ibuf_no_overflow: assert property (@(posedge Clk) disable iff (Reset)
        fifo_push |-> (!fifo_full || fifo_pop));
    a_tag_no_overflow:  assert property (@(posedge Clk) disable iff (Reset) hs |-> !tag_full);
    a_tag_has_entry:    assert property (@(posedge Clk) disable iff (Reset) rsp |-> !tag_empty);
    a_tag_tracks_out:   assert property (@(posedge Clk) disable iff (Reset) tag_count == outstanding_q);
    a_discard_bound:    assert property (@(posedge Clk) disable iff (Reset) discard_q <= outstanding_q);
    a_out_bound:        assert property (@(posedge Clk) disable iff (Reset)
        int'(outstanding_q) <= MAX_OUTSTANDING);
    a_rvalid_expected:  assert property (@(posedge Clk) disable iff (Reset)
        bus.IMem_rvalid |-> (outstanding_q != '0));

endmodule
